// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types for the round-robin stream multiplexer
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_t;

endpackage

// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - N-channel input bundle and single output stream of the mux
interface stream_mux_rr_if #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_CH     = 4,
    parameter int SEL_W      = $clog2(NUM_CH)
);
    logic [NUM_CH*DATA_WIDTH-1:0] data_in;
    logic [NUM_CH-1:0]            valid_in;
    logic [NUM_CH-1:0]            ready_out;
    logic [SEL_W-1:0]             sel_in;
    logic                         mode_in;
    logic [DATA_WIDTH-1:0]        y_out;
    logic                         y_valid_out;
    logic                         y_ready_in;
    logic [SEL_W-1:0]             grant_out;

    modport master (
        output data_in, valid_in, sel_in, mode_in, y_ready_in,
        input  ready_out, y_out, y_valid_out, grant_out
    );

    modport slave (
        input  data_in, valid_in, sel_in, mode_in, y_ready_in,
        output ready_out, y_out, y_valid_out, grant_out
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, scanning upward from ptr+1
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [SEL_W-1:0]  o_idx,
    output logic              o_valid
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        // The last-granted channel is visited last, which gives the fairness rotation.
        for (int i = 1; i <= NUM_CH; i++) begin
            automatic int c = (int'(i_ptr) + i) % NUM_CH;
            if (!o_valid && i_req[SEL_W'(c)]) begin
                o_valid              = 1'b1;
                o_idx                = SEL_W'(c);
                o_grant[SEL_W'(c)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - registered N-to-1 stream mux with fixed or round-robin selection
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_CH     = 4,
    parameter int SEL_W      = $clog2(NUM_CH)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    stream_mux_rr_if.slave bus
);

    logic [DATA_WIDTH-1:0] r_y;
    logic                  r_y_valid;
    logic [SEL_W-1:0]      r_grant;
    logic [SEL_W-1:0]      r_ptr;

    logic [NUM_CH-1:0]     w_rr_grant;
    logic [SEL_W-1:0]      w_rr_idx;
    logic                  w_rr_valid;
    logic                  w_sel_in_range;
    logic                  w_fix_ok;
    logic                  w_cand_ok;
    logic [SEL_W-1:0]      w_cand_idx;
    logic [NUM_CH-1:0]     w_cand_onehot;
    logic                  w_slot_free;
    logic                  w_xfer;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .i_req   (bus.valid_in),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    generate
        if (NUM_CH == (1 << SEL_W)) begin : g_sel_full
            assign w_sel_in_range = 1'b1;
        end else begin : g_sel_part
            assign w_sel_in_range = (int'(bus.sel_in) < NUM_CH);
        end
    endgenerate

    assign w_fix_ok = w_sel_in_range && bus.valid_in[bus.sel_in];

    always_comb begin
        w_cand_ok     = 1'b0;
        w_cand_idx    = '0;
        w_cand_onehot = '0;
        if (bus.mode_in == MODE_RR) begin
            w_cand_ok     = w_rr_valid;
            w_cand_idx    = w_rr_idx;
            w_cand_onehot = w_rr_grant;
        end else begin
            w_cand_ok     = w_fix_ok;
            w_cand_idx    = bus.sel_in;
            w_cand_onehot = NUM_CH'(1) << bus.sel_in;
        end
    end

    // A full slot being drained this cycle may be refilled on the same edge.
    assign w_slot_free   = !r_y_valid || bus.y_ready_in;
    assign w_xfer        = rst_n_in && w_slot_free && w_cand_ok;
    assign bus.ready_out = w_xfer ? w_cand_onehot : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_grant   <= '0;
            r_ptr     <= SEL_W'(NUM_CH - 1);
        end else if (w_xfer) begin
            r_y       <= bus.data_in[w_cand_idx*DATA_WIDTH +: DATA_WIDTH];
            r_y_valid <= 1'b1;
            r_grant   <= w_cand_idx;
            r_ptr     <= w_cand_idx;
        end else if (w_slot_free) begin
            r_y_valid <= 1'b0;
        end
    end

    assign bus.y_out       = r_y;
    assign bus.y_valid_out = r_y_valid;
    assign bus.grant_out   = r_grant;

endmodule
